// File: rtl/crossbar_out.sv
// crossbar_out: 3-source to 3-output crossbar, each output backed by a fall-through FIFO.
// Define XBAR_STATS_EN to add saturating per-port push counters (flit_cnt_*).
module crossbar_out #(
    parameter int DATA_W = 40,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        control_x,
    input  logic [1:0]        control_y,
    input  logic [1:0]        control_local,
    input  logic [DATA_W-1:0] din_x,
    input  logic [DATA_W-1:0] din_y,
    input  logic [DATA_W-1:0] din_local,
    input  logic [2:0]        din_valid,
    output logic [2:0]        din_ready,
    output logic [DATA_W-1:0] dout_x,
    output logic [DATA_W-1:0] dout_y,
    output logic [DATA_W-1:0] dout_local,
    output logic [2:0]        dout_valid,
    input  logic [2:0]        dout_ready,
    output logic              conflict
`ifdef XBAR_STATS_EN
    ,
    output logic [15:0]       flit_cnt_x,
    output logic [15:0]       flit_cnt_y,
    output logic [15:0]       flit_cnt_local
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Index 2 = x, 1 = y, 0 = local for both ports and sources.
    logic [1:0]        ctl       [3];
    logic [DATA_W-1:0] din_arr   [3];
    logic [DATA_W-1:0] dout_arr  [3];
    logic [1:0]        src_sel   [3];
    logic [2:0]        grant;
    logic [2:0]        push;
    logic [2:0]        pop;
    logic [3:0]        valid_pad;
    logic              dup_sel;
    logic              conflict_reg;

    assign ctl[2]     = control_x;
    assign ctl[1]     = control_y;
    assign ctl[0]     = control_local;
    assign din_arr[2] = din_x;
    assign din_arr[1] = din_y;
    assign din_arr[0] = din_local;
    assign valid_pad  = {1'b0, din_valid};

    // Fixed priority x > y > local: a lower port loses any source already claimed above it.
    always_comb begin
        grant    = 3'b000;
        grant[2] = (ctl[2] != 2'b00);
        grant[1] = (ctl[1] != 2'b00) && (ctl[1] != ctl[2]);
        grant[0] = (ctl[0] != 2'b00) && (ctl[0] != ctl[2]) && (ctl[0] != ctl[1]);
    end

    assign dup_sel = ((ctl[2] != 2'b00) && (ctl[2] == ctl[1])) ||
                     ((ctl[2] != 2'b00) && (ctl[2] == ctl[0])) ||
                     ((ctl[1] != 2'b00) && (ctl[1] == ctl[0]));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_port
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic              room;

            // Control code 01/10/11 maps onto source index 2/1/0.
            assign src_sel[gi] = 2'd3 - ctl[gi];
            // A full FIFO still accepts when its head leaves on the same edge.
            assign room        = (count_reg < FULL_CNT) || dout_ready[gi];
            assign push[gi]    = !rst_n && grant[gi] && valid_pad[src_sel[gi]] && room;
            assign pop[gi]     = !rst_n && (count_reg != '0) && dout_ready[gi];

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem[wr_ptr_reg] <= din_arr[src_sel[gi]];
                end
            end

            always_ff @(posedge clk) begin
                if (rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push[gi], pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end

            // Head is read asynchronously so a pushed flit is visible right after its edge.
            assign dout_valid[gi] = (count_reg != '0);
            assign dout_arr[gi]   = dout_valid[gi] ? mem[rd_ptr_reg] : '0;
        end
    endgenerate

    always_comb begin
        din_ready = 3'b000;
        for (int p = 0; p < 3; p++) begin
            if (push[p]) begin
                din_ready[src_sel[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            conflict_reg <= 1'b0;
        end else begin
            conflict_reg <= dup_sel;
        end
    end

    assign conflict   = conflict_reg;
    assign dout_x     = dout_arr[2];
    assign dout_y     = dout_arr[1];
    assign dout_local = dout_arr[0];

`ifdef XBAR_STATS_EN
    logic [15:0] flit_cnt_reg [3];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_stats
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    flit_cnt_reg[gi] <= '0;
                end else if (push[gi] && (flit_cnt_reg[gi] != 16'hFFFF)) begin
                    flit_cnt_reg[gi] <= flit_cnt_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign flit_cnt_x     = flit_cnt_reg[2];
    assign flit_cnt_y     = flit_cnt_reg[1];
    assign flit_cnt_local = flit_cnt_reg[0];
`endif

endmodule

// File: tb/tb_crossbar_out.sv
// Self-checking bench for crossbar_out: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_crossbar_out;

    localparam int DATA_W = 40;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        control_x, control_y, control_local;
    logic [DATA_W-1:0] din_x, din_y, din_local;
    logic [2:0]        din_valid;
    logic [2:0]        din_ready;
    logic [DATA_W-1:0] dout_x, dout_y, dout_local;
    logic [2:0]        dout_valid;
    logic [2:0]        dout_ready;
    logic              conflict;
`ifdef XBAR_STATS_EN
    logic [15:0]       flit_cnt_x, flit_cnt_y, flit_cnt_local;
`endif

    always #5 clk = ~clk;

    crossbar_out #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .control_x     (control_x),
        .control_y     (control_y),
        .control_local (control_local),
        .din_x         (din_x),
        .din_y         (din_y),
        .din_local     (din_local),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dout_x        (dout_x),
        .dout_y        (dout_y),
        .dout_local    (dout_local),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .conflict      (conflict)
`ifdef XBAR_STATS_EN
        ,
        .flit_cnt_x    (flit_cnt_x),
        .flit_cnt_y    (flit_cnt_y),
        .flit_cnt_local(flit_cnt_local)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per output port (2 = x, 1 = y, 0 = local).
    logic [DATA_W-1:0] mq [3][$];
    logic [2:0]        exp_rdy;
    logic [2:0]        exp_push;
    int                exp_src [3];
    bit                exp_dup;
    bit                exp_conf;
    logic [DATA_W-1:0] dout_arr [3];

    assign dout_arr[2] = dout_x;
    assign dout_arr[1] = dout_y;
    assign dout_arr[0] = dout_local;

    function automatic logic [DATA_W-1:0] src_data(input int s);
        case (s)
            2:       return din_x;
            1:       return din_y;
            default: return din_local;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    task automatic model_eval();
        logic [1:0] c [3];
        logic [2:0] taken;
        int s;
        c[2] = control_x;
        c[1] = control_y;
        c[0] = control_local;
        taken    = '0;
        exp_dup  = 1'b0;
        exp_push = '0;
        exp_rdy  = '0;
        for (int p = 2; p >= 0; p--) begin
            exp_src[p] = 0;
            if (c[p] != 2'b00) begin
                s = (c[p] == 2'b01) ? 2 : (c[p] == 2'b10) ? 1 : 0;
                if (taken[s]) begin
                    exp_dup = 1'b1;
                end else begin
                    taken[s]   = 1'b1;
                    exp_src[p] = s;
                    if (din_valid[s] && (mq[p].size() < DEPTH || dout_ready[p])) begin
                        exp_push[p] = 1'b1;
                        exp_rdy[s]  = 1'b1;
                    end
                end
            end
        end
        if (rst_n) begin
            exp_push = '0;
            exp_rdy  = '0;
        end
    endtask

    task automatic set_inputs(input logic rst, input logic [1:0] cx, input logic [1:0] cy,
                              input logic [1:0] cl, input logic [2:0] v, input logic [2:0] r,
                              input logic [DATA_W-1:0] dx, input logic [DATA_W-1:0] dy,
                              input logic [DATA_W-1:0] dl);
        rst_n         = rst;
        control_x     = cx;
        control_y     = cy;
        control_local = cl;
        din_valid     = v;
        dout_ready    = r;
        din_x         = dx;
        din_y         = dy;
        din_local     = dl;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int p = 0; p < 3; p++) mq[p].delete();
            exp_conf = 1'b0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (mq[p].size() > 0 && dout_ready[p]) void'(mq[p].pop_front());
                if (exp_push[p]) mq[p].push_back(src_data(exp_src[p]));
            end
            exp_conf = exp_dup;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_inputs(1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        tick();
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
    endtask

    task automatic test_reset();
        set_inputs(1'b1, 2'b01, 2'b01, 2'b11, 3'b111, 3'b000, rand_data(), rand_data(), rand_data());
        #1;
        checks++;
        if (din_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_din_ready: got %b expected 000", din_ready);
        end
        tick();
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (dout_valid !== 3'b000 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b conflict=%b expected 000/0", dout_valid, conflict);
        end
        checks++;
        if (dout_x !== '0 || dout_y !== '0 || dout_local !== '0) begin
            errors++;
            $display("FAIL reset_dout_zero: got %h %h %h expected 0", dout_x, dout_y, dout_local);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        set_inputs(1'b0, 2'b00, 2'b01, 2'b00, 3'b100, 3'b000, 40'h12345, '0, '0);
        #1;
        checks++;
        if (din_ready !== 3'b100) begin
            errors++;
            $display("FAIL basic_din_ready: got %b expected 100", din_ready);
        end
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (dout_valid !== 3'b010 || dout_y !== 40'h12345 || dout_x !== '0) begin
            errors++;
            $display("FAIL basic_dout: got valid=%b y=%h x=%h expected 010/12345/0", dout_valid, dout_y, dout_x);
        end
        $display("test_basic done");
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] exp_seq [4];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_inputs(1'b0, 2'b11, 2'b00, 2'b00, 3'b001, 3'b000, '0, '0, DATA_W'(40'hA00 + i));
            #1;
            checks++;
            if (din_ready !== ((i < 4) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL full_fill[%0d]: got %b expected %b", i, din_ready, (i < 4) ? 3'b001 : 3'b000);
            end
            tick();
        end
        set_inputs(1'b0, 2'b11, 2'b00, 2'b00, 3'b001, 3'b100, '0, '0, 40'hB00);
        #1;
        checks++;
        if (din_ready !== 3'b001 || dout_x !== 40'hA00) begin
            errors++;
            $display("FAIL full_push_pop: got rdy=%b head=%h expected 001/a00", din_ready, dout_x);
        end
        tick();
        set_inputs(1'b0, 2'b11, 2'b00, 2'b00, 3'b001, 3'b000, '0, '0, 40'hC00);
        #1;
        checks++;
        if (din_ready !== 3'b000 || dout_x !== 40'hA01 || dout_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL full_count_kept: got rdy=%b head=%h v=%b expected 000/a01/1", din_ready, dout_x, dout_valid[2]);
        end
        tick();
        exp_seq = '{40'hA01, 40'hA02, 40'hA03, 40'hB00};
        for (int i = 0; i < 4; i++) begin
            set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b100, '0, '0, '0);
            #1;
            checks++;
            if (dout_x !== exp_seq[i]) begin
                errors++;
                $display("FAIL full_drain[%0d]: got %h expected %h", i, dout_x, exp_seq[i]);
            end
            tick();
        end
        $display("test_full done");
    endtask

    task automatic test_conflict();
        do_reset();
        set_inputs(1'b0, 2'b10, 2'b00, 2'b10, 3'b010, 3'b000, '0, 40'h777, '0);
        #1;
        checks++;
        if (din_ready !== 3'b010) begin
            errors++;
            $display("FAIL conflict_din_ready: got %b expected 010", din_ready);
        end
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (dout_valid !== 3'b100 || dout_x !== 40'h777 || conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_grant: got valid=%b x=%h conflict=%b expected 100/777/1", dout_valid, dout_x, conflict);
        end
        tick();
        #1;
        checks++;
        if (conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear: got %b expected 0", conflict);
        end
        $display("test_conflict done");
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] sent [6];
        logic [DATA_W-1:0] got [$];
        int n_sent;
        logic v;
        logic [2:0] r;
        do_reset();
        for (int k = 0; k < 6; k++) sent[k] = rand_data();
        n_sent = 0;
        for (int i = 0; i < 20; i++) begin
            v = (n_sent < 6) && (i % 3 != 2);
            r = ((i % 2 == 1) || i >= 12) ? 3'b001 : 3'b000;
            set_inputs(1'b0, 2'b00, 2'b00, 2'b01, v ? 3'b100 : 3'b000, r,
                       (n_sent < 6) ? sent[n_sent] : '0, '0, '0);
            #1;
            checks++;
            if (din_ready !== exp_rdy) begin
                errors++;
                $display("FAIL wrap_din_ready[%0d]: got %b expected %b", i, din_ready, exp_rdy);
            end
            if (dout_valid[0] && r[0]) got.push_back(dout_local);
            if (exp_rdy[2]) n_sent++;
            tick();
        end
        checks++;
        if (got.size() != 6) begin
            errors++;
            $display("FAIL wrap_count: got %0d flits expected 6", got.size());
        end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            checks++;
            if (got[k] !== sent[k]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %h expected %h", k, got[k], sent[k]);
            end
        end
        checks++;
        if (dout_valid[0] !== 1'b0 || dout_local !== '0) begin
            errors++;
            $display("FAIL wrap_empty: got v=%b data=%h expected 0/0", dout_valid[0], dout_local);
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b0, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, DATA_W'(40'h300 + i), '0, '0);
            tick();
        end
        set_inputs(1'b1, 2'b01, 2'b00, 2'b00, 3'b100, 3'b100, 40'h999, '0, '0);
        #1;
        checks++;
        if (din_ready !== 3'b000 || dout_valid !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_pre: got rdy=%b valid=%b expected 000/100", din_ready, dout_valid);
        end
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (dout_valid !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_flush: got %b expected 000", dout_valid);
        end
        set_inputs(1'b0, 2'b01, 2'b00, 2'b00, 3'b100, 3'b000, 40'h555, '0, '0);
        #1;
        checks++;
        if (din_ready !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_accept: got %b expected 100", din_ready);
        end
        tick();
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (dout_valid !== 3'b100 || dout_x !== 40'h555) begin
            errors++;
            $display("FAIL mid_reset_new: got valid=%b x=%h expected 100/555", dout_valid, dout_x);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_inputs(($urandom_range(59) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
                       3'($urandom), 3'($urandom), rand_data(), rand_data(), rand_data());
            #1;
            checks++;
            if (din_ready !== exp_rdy || conflict !== exp_conf) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got rdy=%b conf=%b expected %b/%b", i, din_ready, conflict, exp_rdy, exp_conf);
            end
            for (int p = 0; p < 3; p++) begin
                exp_d = (mq[p].size() > 0) ? mq[p][0] : '0;
                checks++;
                if (dout_valid[p] !== (mq[p].size() > 0) || dout_arr[p] !== exp_d) begin
                    errors++;
                    $display("FAIL rand_port%0d[%0d]: got v=%b d=%h expected %b/%h", p, i, dout_valid[p], dout_arr[p], mq[p].size() > 0, exp_d);
                end
            end
            tick();
        end
        $display("test_random done");
    endtask

`ifdef XBAR_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            if (i == 10) begin
                #1;
                checks++;
                if (flit_cnt_y !== 16'd10) begin
                    errors++;
                    $display("FAIL stats_partial: got %0d expected 10", flit_cnt_y);
                end
            end
            set_inputs(1'b0, 2'b00, 2'b10, 2'b00, 3'b010, 3'b010, '0, DATA_W'(i), '0);
            tick();
        end
        set_inputs(1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, '0, '0, '0);
        #1;
        checks++;
        if (flit_cnt_y !== 16'hFFFF || flit_cnt_x !== 16'd0) begin
            errors++;
            $display("FAIL stats_saturate: got y=%h x=%h expected ffff/0000", flit_cnt_y, flit_cnt_x);
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_conflict();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef XBAR_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crossbar_out.md
CROSSBAR_OUT -- requirements
Module: crossbar_out

Interface
REQ-001 Parameter DATA_W, default 40, flit width in bits.
REQ-002 Parameter DEPTH, default 4, output FIFO entries per port; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-high despite the name.
REQ-005 control_x, control_y, control_local  input  2 each  source select per output port: 00 idle, 01 source x, 10 source y, 11 source local.
REQ-006 din_x, din_y, din_local  input  DATA_W each  source flits.
REQ-007 din_valid  input  3  source valid; bit2 = x, bit1 = y, bit0 = local.
REQ-008 din_ready  output  3  source accepted this cycle; same bit order as din_valid.
REQ-009 dout_x, dout_y, dout_local  output  DATA_W each  head flit of each output FIFO.
REQ-010 dout_valid  output  3  output FIFO non-empty; bit2 = x, bit1 = y, bit0 = local.
REQ-011 dout_ready  input  3  downstream pop request per output port.
REQ-012 conflict  output  1  registered pulse: two or more active controls selected the same source in the previous cycle.

Function
REQ-013 Each output port SHALL own a DEPTH-entry FIFO with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH, plus an occupancy count of width log2(DEPTH)+1.
REQ-014 Duplicate selection: output priority is x > y > local; only the highest-priority port selecting a source is granted, and lower-priority ports selecting that source are treated as idle.
REQ-015 Push on port p SHALL occur when control_p != 00, p is granted, the selected din_valid bit is 1, and (count_p < DEPTH, or count_p == DEPTH and dout_ready[p] is 1).
REQ-016 din_ready[s] SHALL be combinational and equal 1 exactly when some port pushes source s this cycle; it is 0 whenever rst_n is 1.
REQ-017 Pop on port p SHALL occur when dout_valid[p] and dout_ready[p] are both 1; dout_ready with an empty FIFO SHALL be ignored.
REQ-018 Simultaneous push and pop on one port SHALL leave the count unchanged and advance both pointers.
REQ-019 A flit pushed at edge N SHALL appear on dout_p with dout_valid[p] = 1 after edge N (first-word fall-through; 1-cycle latency).
REQ-020 dout_p SHALL equal 0 while dout_valid[p] is 0.
REQ-021 The FIFO SHALL preserve order per port; ports are independent, and one full port SHALL NOT stall the other ports.
REQ-022 conflict SHALL be set 1 cycle after a cycle with a duplicate active selection (valid or not), and cleared otherwise.

Reset
REQ-023 While rst_n is 1 at an edge, all pointers, counts, dout_valid, and conflict SHALL become 0; FIFO memory contents need not be cleared.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered flits, and no push or pop SHALL occur on that edge.

Configuration
REQ-025 Macro XBAR_STATS_EN defined: adds outputs flit_cnt_x, flit_cnt_y, flit_cnt_local (16 bits each), which count pushes per port, saturate at 16'hFFFF, and reset to 0.
REQ-026 Macro XBAR_STATS_EN undefined: these ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-027 Reset, then control_y = 01, din_valid = 100, din_x = 40'h12345, dout_ready = 000 -> din_ready = 100; next cycle dout_valid = 010 and dout_y = 40'h12345.
REQ-028 control_x = 11 held, local source valid every cycle, dout_ready = 000 -> exactly 4 pushes, then din_ready[0] = 0; set dout_ready[2] = 1 -> push and pop in the same cycle, count stays 4.
REQ-029 control_x = 10 and control_local = 10 with y valid -> only port x receives the flit, din_ready = 010, conflict = 1 on the next cycle only.
REQ-030 Push 6 flits through port local with interleaved pops (pointer wrap) -> output order identical to input order and dout_local = 0 when empty.
REQ-031 Assert rst_n with 3 flits buffered on port x -> dout_valid = 000 the next cycle, and new flits are accepted from an empty FIFO.
REQ-032 XBAR_STATS_EN defined: 70000 pushes on port y -> flit_cnt_y = 16'hFFFF; flit_cnt_x unaffected.
